ram_bus_arbiter: RTL and testbench

- Shares the single byte-wide SDRAM port (sdram oe/we/addr/din/dout) between two requesters:
  - r0: program uploader / loader DMA.
  - r1: HC800 CPU ramBus.
- Runs in the bus clock domain, the clkref domain of the sdram controller.
- Serialises one access at a time through a small FSM.
- Returns read data and a one-cycle ack to the winning requester only.

---
 rtl/ram_arb_pkg.sv | 15 +
 rtl/ram_arb_select.sv | 23 ++
 rtl/ram_bus_arbiter.sv | 184 ++++++++++++++++++
 tb/tb_ram_bus_arbiter.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/ram_arb_pkg.sv
// Shared state encoding, grant encodings and default timing for the SDRAM port arbiter.
package ram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCESS  = 2'd1,
    RECOVER = 2'd2
  } arb_state_e;

  localparam logic REQ_UPLOAD = 1'b0;
  localparam logic REQ_CPU    = 1'b1;

  localparam int unsigned ACCESS_CYCLES_DEFAULT = 2;

endpackage

// File: rtl/ram_arb_select.sv
// Combinational winner selection between the loader DMA (r0) and the CPU (r1).
module ram_arb_select
  import ram_arb_pkg::*;
(
  input  logic r0_req,
  input  logic r1_req,
  input  logic last_grant,
  output logic valid,
  output logic winner
);

  always_comb begin
    valid  = r0_req | r1_req;
    winner = REQ_UPLOAD;
    // On contention the side that did not own the previous access goes next
    if (r0_req && r1_req) begin
      winner = ~last_grant;
    end else if (r1_req) begin
      winner = REQ_CPU;
    end
  end

endmodule

// File: rtl/ram_bus_arbiter.sv
// Serialises r0 (loader DMA) and r1 (CPU) byte accesses onto the shared SDRAM port.
// Define RAM_ARB_ROUND_ROBIN_EN to alternate grants under contention; otherwise r0 has fixed priority.
module ram_bus_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned ADDR_W        = 21,
  parameter int unsigned ACCESS_CYCLES = ACCESS_CYCLES_DEFAULT
) (
  input  logic              bus_clk,
  input  logic              bus_reset_n,
  input  logic              r0_req,
  input  logic              r0_write,
  input  logic [ADDR_W-1:0] r0_addr,
  input  logic [7:0]        r0_wdata,
  output logic              r0_ack,
  output logic [7:0]        r0_rdata,
  input  logic              r1_req,
  input  logic              r1_write,
  input  logic [ADDR_W-1:0] r1_addr,
  input  logic [7:0]        r1_wdata,
  output logic              r1_ack,
  output logic [7:0]        r1_rdata,
  output logic              mem_enable,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_address,
  output logic [7:0]        mem_wdata,
  input  logic [15:0]       mem_rdata,
  output logic              grant,
  output logic              busy
);

  localparam int unsigned      CNT_W    = $clog2(ACCESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ACCESS_CYCLES - 1);

  arb_state_e        r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_mem_enable, w_mem_enable_nxt;
  logic              r_mem_write, w_mem_write_nxt;
  logic [ADDR_W-1:0] r_mem_address, w_mem_address_nxt;
  logic [7:0]        r_mem_wdata, w_mem_wdata_nxt;
  logic              r_grant, w_grant_nxt;
  logic              r_busy, w_busy_nxt;
  logic              r_r0_ack, w_r0_ack_nxt;
  logic              r_r1_ack, w_r1_ack_nxt;
  logic [7:0]        r_r0_rdata, w_r0_rdata_nxt;
  logic [7:0]        r_r1_rdata, w_r1_rdata_nxt;

  logic              w_valid;
  logic              w_winner;
  logic              w_last_grant;
  logic              w_unused_rdata_hi;

  // The SDRAM word is driven with the byte duplicated; only the low lane carries our data
  assign w_unused_rdata_hi = ^mem_rdata[15:8];

`ifdef RAM_ARB_ROUND_ROBIN_EN
  logic r_last_grant, w_last_grant_nxt;

  assign w_last_grant     = r_last_grant;
  assign w_last_grant_nxt = (r_state == IDLE && w_valid) ? w_winner : r_last_grant;

  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      r_last_grant <= 1'b0;
    end else begin
      r_last_grant <= w_last_grant_nxt;
    end
  end
`else
  // Pretending r1 always went last makes every tie resolve to r0
  assign w_last_grant = REQ_CPU;
`endif

  ram_arb_select u_select (
    .r0_req     (r0_req),
    .r1_req     (r1_req),
    .last_grant (w_last_grant),
    .valid      (w_valid),
    .winner     (w_winner)
  );

  // Next-state and next-output logic
  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_mem_enable_nxt  = r_mem_enable;
    w_mem_write_nxt   = r_mem_write;
    w_mem_address_nxt = r_mem_address;
    w_mem_wdata_nxt   = r_mem_wdata;
    w_grant_nxt       = r_grant;
    w_r0_ack_nxt      = 1'b0;
    w_r1_ack_nxt      = 1'b0;
    w_r0_rdata_nxt    = r_r0_rdata;
    w_r1_rdata_nxt    = r_r1_rdata;

    case (r_state)
      IDLE: begin
        if (w_valid) begin
          w_state_nxt       = ACCESS;
          w_cnt_nxt         = '0;
          w_mem_enable_nxt  = 1'b1;
          w_grant_nxt       = w_winner;
          w_mem_write_nxt   = (w_winner == REQ_CPU) ? r1_write : r0_write;
          w_mem_address_nxt = (w_winner == REQ_CPU) ? r1_addr  : r0_addr;
          w_mem_wdata_nxt   = (w_winner == REQ_CPU) ? r1_wdata : r0_wdata;
        end
      end

      ACCESS: begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
        if (r_cnt == CNT_LAST) begin
          w_state_nxt      = RECOVER;
          w_mem_enable_nxt = 1'b0;
          w_mem_write_nxt  = 1'b0;
          if (r_grant == REQ_CPU) begin
            w_r1_ack_nxt = 1'b1;
            if (!r_mem_write) w_r1_rdata_nxt = mem_rdata[7:0];
          end else begin
            w_r0_ack_nxt = 1'b1;
            if (!r_mem_write) w_r0_rdata_nxt = mem_rdata[7:0];
          end
        end
      end

      RECOVER: begin
        w_state_nxt = IDLE;
      end

      default: begin
        w_state_nxt = IDLE;
      end
    endcase

    w_busy_nxt = (w_state_nxt != IDLE);
  end

  always_ff @(posedge bus_clk or negedge bus_reset_n) begin
    if (!bus_reset_n) begin
      r_state       <= IDLE;
      r_cnt         <= '0;
      r_mem_enable  <= 1'b0;
      r_mem_write   <= 1'b0;
      r_mem_address <= '0;
      r_mem_wdata   <= '0;
      r_grant       <= 1'b0;
      r_busy        <= 1'b0;
      r_r0_ack      <= 1'b0;
      r_r1_ack      <= 1'b0;
      r_r0_rdata    <= '0;
      r_r1_rdata    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_mem_enable  <= w_mem_enable_nxt;
      r_mem_write   <= w_mem_write_nxt;
      r_mem_address <= w_mem_address_nxt;
      r_mem_wdata   <= w_mem_wdata_nxt;
      r_grant       <= w_grant_nxt;
      r_busy        <= w_busy_nxt;
      r_r0_ack      <= w_r0_ack_nxt;
      r_r1_ack      <= w_r1_ack_nxt;
      r_r0_rdata    <= w_r0_rdata_nxt;
      r_r1_rdata    <= w_r1_rdata_nxt;
    end
  end

  assign mem_enable  = r_mem_enable;
  assign mem_write   = r_mem_write;
  assign mem_address = r_mem_address;
  assign mem_wdata   = r_mem_wdata;
  assign grant       = r_grant;
  assign busy        = r_busy;
  assign r0_ack      = r_r0_ack;
  assign r1_ack      = r_r1_ack;
  assign r0_rdata    = r_r0_rdata;
  assign r1_rdata    = r_r1_rdata;

  // Port-level invariants the SDRAM side relies on
  a_we_needs_oe : assert property (@(posedge bus_clk) disable iff (!bus_reset_n)
    mem_write |-> mem_enable);
  a_single_ack  : assert property (@(posedge bus_clk) disable iff (!bus_reset_n)
    !(r0_ack && r1_ack));

endmodule

// File: tb/tb_ram_bus_arbiter.sv
// Randomised bench for ram_bus_arbiter against a transaction-level model of the two requesters and memory.
module tb_ram_bus_arbiter;
  import ram_arb_pkg::*;

  localparam int unsigned ADDR_W = 21;
  localparam int unsigned AC     = 2;
  localparam int          BOUND  = 60;

  logic              bus_clk     = 1'b0;
  logic              bus_reset_n = 1'b0;
  logic              r0_req = 1'b0, r0_write = 1'b0;
  logic [ADDR_W-1:0] r0_addr = '0;
  logic [7:0]        r0_wdata = '0;
  logic              r1_req = 1'b0, r1_write = 1'b0;
  logic [ADDR_W-1:0] r1_addr = '0;
  logic [7:0]        r1_wdata = '0;
  logic [15:0]       mem_rdata = '0;
  logic              r0_ack, r1_ack, mem_enable, mem_write, grant, busy;
  logic [7:0]        r0_rdata, r1_rdata, mem_wdata;
  logic [ADDR_W-1:0] mem_address;

  int         n_checks = 0;
  int         n_pass   = 0;
  logic [7:0] sdram   [int];
  logic [7:0] ref_mem [int];
  logic [7:0] m_rdata [2];
  bit         m_last;
  logic       en_seen, ack_seen;

  always #5 bus_clk = ~bus_clk;

  ram_bus_arbiter #(.ADDR_W(ADDR_W), .ACCESS_CYCLES(AC)) dut (
    .bus_clk(bus_clk), .bus_reset_n(bus_reset_n),
    .r0_req(r0_req), .r0_write(r0_write), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_write(r1_write), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_enable(mem_enable), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .grant(grant), .busy(busy)
  );

  // Byte-wide SDRAM model; high lane carries a fixed pattern that must be ignored
  always @(posedge bus_clk) if (mem_enable && mem_write) sdram[int'(mem_address)] = mem_wdata;
  always @(negedge bus_clk)
    mem_rdata = {8'h55, sdram.exists(int'(mem_address)) ? sdram[int'(mem_address)] : 8'h00};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  function automatic logic [7:0] ref_rd(input logic [ADDR_W-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : 8'h00;
  endfunction

  function automatic bit pick(input bit p0, input bit p1);
`ifdef RAM_ARB_ROUND_ROBIN_EN
    if (p0 && p1) return ~m_last;
`else
    if (p0 && p1) return 1'b0;
`endif
    return p1;
  endfunction

  // Raise the wanted requests, follow every access to its ack, drop each req on its ack
  task automatic serve(input bit w0, input bit wr0, input logic [ADDR_W-1:0] a0, input logic [7:0] d0,
                       input bit w1, input bit wr1, input logic [ADDR_W-1:0] a1, input logic [7:0] d1,
                       input bit scramble);
    bit done [2];
    bit wr [2];
    logic [ADDR_W-1:0] ad [2];
    logic [7:0] wd [2];
    bit cur, in_burst, cmd_ok, we_bad;
    int len, start, last_ack, cyc;
    done[0] = !w0; done[1] = !w1;
    wr[0] = wr0; wr[1] = wr1; ad[0] = a0; ad[1] = a1; wd[0] = d0; wd[1] = d1;
    r0_req = w0; r0_write = wr0; r0_addr = a0; r0_wdata = d0;
    r1_req = w1; r1_write = wr1; r1_addr = a1; r1_wdata = d1;
    cur = 1'b0; in_burst = 1'b0; cmd_ok = 1'b1; we_bad = 1'b0;
    len = 0; start = 0; last_ack = -1; cyc = 0;
    while (!(done[0] && done[1]) && cyc < BOUND) begin
      @(negedge bus_clk);
      cyc++;
      if (mem_write && !mem_enable) we_bad = 1'b1;
      if (mem_enable && !in_burst) begin
        cur = pick(!done[0], !done[1]);
        m_last = cur;
        in_burst = 1'b1; len = 0; cmd_ok = 1'b1; start = cyc;
        chk("grant", grant, cur);
        chk("start_cycle", cyc, (last_ack < 0) ? 1 : last_ack + 2);
      end
      if (mem_enable) begin
        len++;
        if (mem_address !== ad[cur] || mem_write !== wr[cur] || (wr[cur] && mem_wdata !== wd[cur]))
          cmd_ok = 1'b0;
        if (scramble && len == 1) begin
          if (cur) begin r1_addr = ad[1] ^ ADDR_W'(32'h30); r1_wdata = ~wd[1]; end
          else     begin r0_addr = ad[0] ^ ADDR_W'(32'h30); r0_wdata = ~wd[0]; end
        end
      end
      if (r0_ack || r1_ack) begin
        chk("ack_owner", {r1_ack, r0_ack}, cur ? 2'b10 : 2'b01);
        chk("burst_len", len, AC);
        chk("cmd_stable", cmd_ok, 1);
        chk("ack_latency", cyc, start + AC);
        chk("addr_in_recover", mem_address, ad[cur]);
        chk("busy_recover", busy, 1);
        if (!wr[cur]) m_rdata[cur] = ref_rd(ad[cur]);
        else ref_mem[int'(ad[cur])] = wd[cur];
        chk("r0_rdata", r0_rdata, m_rdata[0]);
        chk("r1_rdata", r1_rdata, m_rdata[1]);
        done[cur] = 1'b1; in_burst = 1'b0; last_ack = cyc;
        if (cur) r1_req = 1'b0; else r0_req = 1'b0;
      end
    end
    chk("serve_done", {done[1], done[0]}, 2'b11);
    chk("we_only_with_oe", we_bad, 0);
    r0_req = 1'b0; r1_req = 1'b0;
    @(negedge bus_clk);
    chk("busy_idle", busy, 0);
  endtask

  // Both requesters hold reads continuously for n accesses
  task automatic hold_both(input int n);
    bit cur, in_burst;
    int cnt, start, last_ack, cyc;
    r0_req = 1'b1; r0_write = 1'b0; r0_addr = ADDR_W'(32'h40);
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = ADDR_W'(32'h41);
    cur = 1'b0; in_burst = 1'b0; cnt = 0; start = 0; last_ack = -1; cyc = 0;
    while (cnt < n && cyc < BOUND * n) begin
      @(negedge bus_clk);
      cyc++;
      if (mem_enable && !in_burst) begin
        cur = pick(1'b1, 1'b1);
        m_last = cur;
        in_burst = 1'b1; start = cyc;
        chk("hold_grant", grant, cur);
        chk("hold_gap", cyc, (last_ack < 0) ? 1 : last_ack + 2);
      end
      if (r0_ack || r1_ack) begin
        chk("hold_owner", {r1_ack, r0_ack}, cur ? 2'b10 : 2'b01);
        chk("hold_latency", cyc, start + AC);
        chk("hold_oe_low", mem_enable, 0);
        m_rdata[cur] = ref_rd(cur ? ADDR_W'(32'h41) : ADDR_W'(32'h40));
        chk("hold_rdata", cur ? r1_rdata : r0_rdata, m_rdata[cur]);
        cnt++; in_burst = 1'b0; last_ack = cyc;
      end
    end
    r0_req = 1'b0; r1_req = 1'b0;
    chk("hold_count", cnt, n);
    @(negedge bus_clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int mode;
    m_rdata[0] = 8'h00; m_rdata[1] = 8'h00; m_last = 1'b0;
    repeat (3) @(negedge bus_clk);
    chk("rst_mem", {mem_enable, mem_write, mem_address, mem_wdata}, 0);
    chk("rst_req", {r0_ack, r1_ack, r0_rdata, r1_rdata}, 0);
    chk("rst_stat", {grant, busy}, 0);
    bus_reset_n = 1'b1;
    en_seen = 1'b0;
    repeat (20) begin @(negedge bus_clk); en_seen = en_seen | mem_enable | busy; end
    chk("idle_quiet", en_seen, 0);

    serve(1'b1, 1'b1, ADDR_W'(32'h00100), 8'h3C, 1'b0, 1'b0, '0, 8'h00, 1'b0);
    chk("sdram_written", sdram['h100], 8'h3C);

    sdram['h1ABCD] = 8'hAA; ref_mem['h1ABCD] = 8'hAA;
    serve(1'b0, 1'b0, '0, 8'h00, 1'b0 | 1'b1, 1'b0, ADDR_W'(32'h1ABCD), 8'h00, 1'b0);
    chk("r1_read_AA", r1_rdata, 8'hAA);

    sdram['h40] = 8'h11; ref_mem['h40] = 8'h11;
    sdram['h41] = 8'h22; ref_mem['h41] = 8'h22;
    hold_both(4);

    // Reset during the second access cycle of an r1 read
    sdram['h777] = 8'h5E; ref_mem['h777] = 8'h5E;
    r1_req = 1'b1; r1_write = 1'b0; r1_addr = ADDR_W'(32'h777);
    @(negedge bus_clk);
    @(negedge bus_clk);
    chk("pre_rst_oe", mem_enable, 1);
    #1 bus_reset_n = 1'b0;
    #1;
    chk("rst_async_oe", mem_enable, 0);
    chk("rst_async_busy", busy, 0);
    m_last = 1'b0; m_rdata[0] = 8'h00; m_rdata[1] = 8'h00;
    ack_seen = 1'b0;
    repeat (3) begin @(posedge bus_clk); #1 ack_seen = ack_seen | r1_ack; end
    chk("rst_no_ack", ack_seen, 0);
    @(negedge bus_clk);
    bus_reset_n = 1'b1;
    serve(1'b0, 1'b0, '0, 8'h00, 1'b1, 1'b0, ADDR_W'(32'h777), 8'h00, 1'b0);
    chk("post_rst_read", r1_rdata, 8'h5E);

    // Address moved from 0x10 to 0x20 after grant
    sdram['h10] = 8'hC3; ref_mem['h10] = 8'hC3;
    serve(1'b1, 1'b0, ADDR_W'(32'h00010), 8'h00, 1'b0, 1'b0, '0, 8'h00, 1'b1);
    chk("addr_change_read", r0_rdata, 8'hC3);

    for (int i = 0; i < 30; i++) begin
      mode = int'($urandom_range(0, 2));
      serve(mode != 1, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), 8'($urandom),
            mode != 0, 1'($urandom_range(0, 1)), ADDR_W'($urandom_range(0, 31)), 8'($urandom),
            1'($urandom_range(0, 1)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
